normalizador_pf: RTL and testbench
==================================

// Module: normalizador_pf
// PURPOSE
// - Normalise/round stage after the single-precision FP adder datapath.
// - Input: sign, larger-operand exponent and raw significand sum with guard/round/sticky (GRS) bits.
// - Iterative left shift (1 bit/cycle), 1-bit right shift on carry, round-to-nearest-even.
// - Output: packed IEEE-754 binary32 result. valid/ready handshake on both sides.
// PARAMETERS
// - EXP_W   8   exponent field width
// - MANT_W  23  stored fraction width; raw sum width is MANT_W+5 (carry, hidden, fraction, G, R, S)
// PORTS
// - clk            in   1         single clock, rising edge
// - rst_n          in   1         asynchronous active-low reset
// - in_valid       in   1         input operand set valid
// - in_ready       out  1         stage can accept (IDLE only)
// - in_sign        in   1         result sign
// - in_exp         in   EXP_W     biased exponent of larger operand
// - in_mant        in   MANT_W+5  [27]=carry [26]=hidden [25:3]=frac [2]=G [1]=R [0]=S
// - out_valid      out  1         result valid, held until out_ready
// - out_ready      in   1         downstream accepts
// - out_result     out  32        {sign, exp, frac}
// - out_overflow   out  1         result forced to +/-Inf by exponent overflow
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE. in_ready=1. out_valid=0. out_result=0. out_overflow=0. Internal regs=0.
// - Reset mid-operation aborts the operation; no output is produced.
// - IDLE: in_ready=1. On in_valid: latch sign/exp/mant, go NORM. in_exp==0 is treated as effective exponent 1.
// - NORM, checked in this priority, one action per cycle:
//   - in_exp==255: go ROUND (special).
//   - mant[27]=1: shift right 1; new S = old R|S; exp+1; go ROUND.
//   - mant==0, or mant[26]=1, or exp<=1: go ROUND.
//   - Otherwise: shift left 1 (shift in 0); exp-1; stay in NORM.
// - ROUND (1 cycle), round-to-nearest-even:
//   - Round up iff G & (R|S|mant[3]); add 1 at bit 3.
//   - Rounding carry into bit 27: shift right 1, exp+1.
//   - Final exp>=255: result {sign,8'hFF,0}, out_overflow=1.
//   - mant==0: result {sign,0,0}.
//   - exp==1 and hidden=0: subnormal, exp field=0.
//   - Special (in_exp==255): {sign,8'hFF,frac}. If frac!=0, force frac[22]=1 (quiet NaN).
//   - Register out_result and go DONE.
// - DONE: out_valid=1, outputs stable. On out_ready: go IDLE (out_valid=0 next cycle).
// - No overlap between operations: in_ready=0 in NORM/ROUND/DONE; in_valid there is ignored.
// - Latency: accept at edge T; NORM from T+1; out_valid at T+3+k, k = left shifts (0..26).
//   - Right-shift/normalised inputs: k=0.
// - Exponent arithmetic in EXP_W+1 bits so that 254+1 and rounding carry cannot wrap.
// TESTING
// - exp=127, mant=28'h8000000 (1.0+1.0) -> out_result=32'h40000000, out_valid exactly 3 cycles after accept.
// - exp=130, mant=28'h0800000 (hidden at bit 23) -> 3 left shifts, 32'h3F800000, out_valid 6 cycles after accept.
// - Exact cancellation: sign=0, mant=0 -> 32'h00000000. Same with sign=1 -> 32'h80000000.
// - Rounding cases, exp=127:
//   - RNE tie, lsb=1: mant=28'h7FFFFFC -> round up, carry -> 32'h40000000.
//   - Tie, lsb=0: mant=28'h4000004 -> 32'h3F800000 (no round-up).
// - exp=254, mant=28'h8000000 -> 32'h7F800000, out_overflow=1.
// - Protocol/robustness:
//   - out_ready=0 for 5 cycles: out_valid and out_result held, in_ready=0.
//   - Assert rst_n=0 during NORM: out_valid=0 and in_ready=1 immediately; no result after release.

Source files
------------

// File: rtl/normalizador_pf.sv
// Normalise and round stage behind the binary32 adder datapath.
// Iterative 1-bit/cycle left shift, carry right shift, RNE rounding.
module normalizador_pf #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic [EXP_W-1:0]        in_exp,
  input  logic [MANT_W+4:0]       in_mant,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+MANT_W:0]   out_result,
  output logic                    out_overflow
);

  localparam int MW = MANT_W + 5;
  localparam int RW = EXP_W + MANT_W + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] NORM  = 2'd1;
  localparam logic [1:0] ROUND = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [EXP_W:0] EXP_ONE = {{EXP_W{1'b0}}, 1'b1};
  localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

  logic [1:0]        state;
  logic              signReg;
  logic              specReg;
  logic [EXP_W:0]    expReg;
  logic [MW-1:0]     mantReg;
  logic [RW-1:0]     resReg;
  logic              ovfReg;

  logic              roundUp;
  logic [MW-1:0]     mantSum;
  logic [MW-1:0]     mantRnd;
  logic [EXP_W:0]    expRnd;
  logic [MANT_W-1:0] fracRnd;
  logic [MANT_W-1:0] fracSp;
  logic [RW-1:0]     resNext;
  logic              ovfNext;

  assign in_ready     = (state == IDLE);
  assign out_valid    = (state == DONE);
  assign out_result   = resReg;
  assign out_overflow = ovfReg;

  always_comb begin
    roundUp = mantReg[2] & (mantReg[1] | mantReg[0] | mantReg[3]);
    mantSum = mantReg + {{(MW-4){1'b0}}, roundUp, 3'b000};
    mantRnd = mantSum;
    expRnd  = expReg;
    if (mantSum[MW-1]) begin
      mantRnd = mantSum >> 1;
      expRnd  = expReg + EXP_ONE;
    end
    fracRnd = mantRnd[MW-3:3];
    fracSp  = mantReg[MW-3:3];
    if (fracSp != '0) fracSp[MANT_W-1] = 1'b1;
    ovfNext = 1'b0;
    // Inf/NaN pass through untouched apart from quieting.
    if (specReg) begin
      resNext = {signReg, {EXP_W{1'b1}}, fracSp};
    end else if (expRnd >= EXP_MAX) begin
      resNext = {signReg, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
      ovfNext = 1'b1;
    end else if (mantRnd == '0) begin
      resNext = {signReg, {(RW-1){1'b0}}};
    end else if (expRnd == EXP_ONE && !mantRnd[MW-2]) begin
      resNext = {signReg, {EXP_W{1'b0}}, fracRnd};
    end else begin
      resNext = {signReg, expRnd[EXP_W-1:0], fracRnd};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      signReg <= 1'b0;
      specReg <= 1'b0;
      expReg  <= '0;
      mantReg <= '0;
      resReg  <= '0;
      ovfReg  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            signReg <= in_sign;
            specReg <= &in_exp;
            expReg  <= (in_exp == '0) ? EXP_ONE : {1'b0, in_exp};
            mantReg <= in_mant;
            state   <= NORM;
          end
        end
        NORM: begin
          if (specReg) begin
            state <= ROUND;
          end else if (mantReg[MW-1]) begin
            mantReg <= {1'b0, mantReg[MW-1:2], mantReg[1] | mantReg[0]};
            expReg  <= expReg + EXP_ONE;
            state   <= ROUND;
          end else if (mantReg == '0 || mantReg[MW-2] ||
                       expReg <= EXP_ONE) begin
            state <= ROUND;
          end else begin
            mantReg <= {mantReg[MW-2:0], 1'b0};
            expReg  <= expReg - EXP_ONE;
          end
        end
        ROUND: begin
          resReg <= resNext;
          ovfReg <= ovfNext;
          state  <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_normalizador_pf.sv
// Bench for normalizador_pf: directed table, protocol sequences,
// and random operands against an arithmetic reference model.
module tb_normalizador_pf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [27:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  normalizador_pf dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sign      (in_sign),
    .in_exp       (in_exp),
    .in_mant      (in_mant),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_overflow (out_overflow)
  );

  typedef struct {
    logic        s;
    logic [7:0]  e;
    logic [27:0] m;
    logic [31:0] res;
    logic        ovf;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  // Reference: value-level normalise then integer round-half-even.
  function automatic void model(input logic s, input logic [7:0] e,
                                input logic [27:0] m,
                                output logic [31:0] res,
                                output logic ovf, output int lat);
    int ex;
    longint unsigned mm, q, rem;
    logic [22:0] frac;
    ovf = 1'b0;
    lat = 3;
    if (e == 8'hFF) begin
      frac = m[25:3];
      if (frac != 0) frac[22] = 1'b1;
      res = {s, 8'hFF, frac};
      return;
    end
    ex = (e == 0) ? 1 : int'(e);
    mm = longint'(m);
    if (mm >= 64'd134217728) begin
      mm = (mm >> 1) | (mm & 64'd1);
      ex++;
    end else if (mm != 0) begin
      while (mm < 64'd67108864 && ex > 1) begin
        mm = mm * 2;
        ex--;
        lat++;
      end
    end
    q = mm / 8;
    rem = mm % 8;
    if (rem > 4 || (rem == 4 && q % 2 == 1)) q = q + 1;
    if (q >= 64'd16777216) begin
      q = q / 2;
      ex++;
    end
    if (ex >= 255) begin
      res = {s, 8'hFF, 23'h0};
      ovf = 1'b1;
    end else if (q == 0) begin
      res = {s, 31'h0};
    end else if (ex == 1 && q < 64'd8388608) begin
      res = {s, 8'h00, q[22:0]};
    end else begin
      res = {s, ex[7:0], q[22:0]};
    end
  endfunction

  task automatic doOp(input logic s, input logic [7:0] e,
                      input logic [27:0] m,
                      output logic [31:0] res, output logic ovf,
                      output int lat);
    bit got;
    @(negedge clk);
    chk("in_ready_idle", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
    @(posedge clk);
    #1 in_valid = 1'b0;
    got = 1'b0;
    lat = 0;
    res = '0;
    ovf = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL timeout: out_valid low after %0d cycles", lat);
      rst_n = 1'b0;
      #1 rst_n = 1'b1;
    end else begin
      res = out_result;
      ovf = out_overflow;
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
    end
  endtask

  task automatic runCheck(input string tag, input logic s,
                          input logic [7:0] e, input logic [27:0] m,
                          input logic [31:0] wRes, input logic wOvf,
                          input int wLat);
    logic [31:0] r;
    logic        o;
    int          l;
    doOp(s, e, m, r, o, l);
    chk({tag, "_result"}, r, wRes);
    chk({tag, "_ovf"}, {31'b0, o}, {31'b0, wOvf});
    chk({tag, "_latency"}, l, wLat);
  endtask

  initial begin
    logic [31:0] r0, mr;
    logic        mo;
    int          ml, seen, sh, sel;
    logic        rs;
    logic [7:0]  re;
    logic [27:0] rm;

    vecs[0]  = '{1'b0, 8'd127, 28'h8000000, 32'h40000000, 1'b0, 3};
    vecs[1]  = '{1'b0, 8'd130, 28'h0800000, 32'h3F800000, 1'b0, 6};
    vecs[2]  = '{1'b0, 8'd100, 28'h0000000, 32'h00000000, 1'b0, 3};
    vecs[3]  = '{1'b1, 8'd100, 28'h0000000, 32'h80000000, 1'b0, 3};
    vecs[4]  = '{1'b0, 8'd127, 28'h7FFFFFC, 32'h40000000, 1'b0, 3};
    vecs[5]  = '{1'b0, 8'd127, 28'h4000004, 32'h3F800000, 1'b0, 3};
    vecs[6]  = '{1'b0, 8'd254, 28'h8000000, 32'h7F800000, 1'b1, 3};
    vecs[7]  = '{1'b0, 8'd255, 28'h4000008, 32'h7FC00001, 1'b0, 3};
    vecs[8]  = '{1'b1, 8'd255, 28'h4000000, 32'hFF800000, 1'b0, 3};
    vecs[9]  = '{1'b0, 8'd0,   28'h0000008, 32'h00000001, 1'b0, 3};
    vecs[10] = '{1'b0, 8'd2,   28'h2000000, 32'h00800000, 1'b0, 4};
    vecs[11] = '{1'b0, 8'd127, 28'h400000C, 32'h3F800002, 1'b0, 3};
    vecs[12] = '{1'b0, 8'd1,   28'h3FFFFFC, 32'h00800000, 1'b0, 3};

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_sign = 1'b0;
    in_exp = '0;
    in_mant = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_overflow", {31'b0, out_overflow}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++)
      runCheck($sformatf("vec%0d", i), vecs[i].s, vecs[i].e, vecs[i].m,
               vecs[i].res, vecs[i].ovf, vecs[i].lat);

    // Back-pressure: result must hold while downstream stalls.
    @(negedge clk);
    in_valid = 1'b1;
    in_sign = 1'b0;
    in_exp = 8'd127;
    in_mant = 28'h8000000;
    @(posedge clk);
    #1 in_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 40 && seen == 0; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk("hold_valid_rise", seen, 1);
    r0 = out_result;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_exp = 8'd3;
      in_mant = 28'h0000010;
      @(negedge clk);
      chk("hold_out_valid", {31'b0, out_valid}, 32'd1);
      chk("hold_out_result", out_result, r0);
      chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    chk("hold_value", r0, 32'h40000000);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("hold_release_valid", {31'b0, out_valid}, 32'd0);
    chk("hold_release_ready", {31'b0, in_ready}, 32'd1);

    // Reset while shifting aborts the operation.
    in_valid = 1'b1;
    in_exp = 8'd200;
    in_mant = 28'h0000008;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("abort_no_result", seen, 0);
    runCheck("after_abort", 1'b1, 8'd127, 28'h8000000,
             32'hC0000000, 1'b0, 3);

    for (int n = 0; n < 150; n++) begin
      rs = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      case (sel)
        0: re = 8'd0;
        1: re = 8'd255;
        2: re = 8'($urandom_range(250, 254));
        3: re = 8'($urandom_range(1, 4));
        default: re = 8'($urandom_range(0, 255));
      endcase
      sh = $urandom_range(0, 27);
      rm = 28'($urandom) >> sh;
      model(rs, re, rm, mr, mo, ml);
      runCheck($sformatf("rnd%0d", n), rs, re, rm, mr, mo, ml);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
